// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type and the counter load helper.
package dmem_resp_pkg;

    localparam int DMEM_LAT_W  = 4;
    localparam int DMEM_DATA_W = 32;

    localparam logic [DMEM_LAT_W-1:0] DMEM_CNT_ZERO = 4'd0;
    localparam logic [DMEM_LAT_W-1:0] DMEM_CNT_ONE  = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Down-counter load value; a zero latency goes straight to RESP and never loads it.
    function automatic logic [DMEM_LAT_W-1:0] lat_load(input int latency);
        if (latency > 32'sd0) begin
            return DMEM_LAT_W'(latency - 32'sd1);
        end else begin
            return DMEM_CNT_ZERO;
        end
    endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Word RAM for the data-memory responder: synchronous write, registered read.
// The array has no reset; rd_clr loads zero into the read register instead.
module dmem_resp_ram
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic                   rd_clr,
    input  logic [IDX_W-1:0]       addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem_r [DEPTH];
    logic [DMEM_DATA_W-1:0] rdata_r;

    // Array write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read data register; writes and errors return zero rather than array contents.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata_r <= {DMEM_DATA_W{1'b0}};
        end else if (rd_en) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one word request per handshake, LATENCY wait cycles, then access.
// Optional upper-address range check: define DMEM_RESP_RANGE_CHECK_EN.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DMEM_LAT_W-1:0] LAT_LOAD = lat_load(LATENCY);
    localparam bit LAT_ZERO = (LATENCY == 32'sd0);

    dmem_state_t state_r;
    dmem_state_t state_s;
    logic [DMEM_LAT_W-1:0]  cnt_r;
    logic                   cap_we_r;
    logic [IDX_W-1:0]       cap_idx_r;
    logic [DMEM_DATA_W-1:0] cap_wdata_r;
    logic                   resp_valid_r;

    logic                   accept_s;
    logic                   enter_resp_s;
    logic                   acc_we_s;
    logic                   acc_oor_s;
    logic [IDX_W-1:0]       acc_idx_s;
    logic [DMEM_DATA_W-1:0] acc_wdata_s;
    logic                   ram_wr_s;
    logic                   ram_rd_s;
    logic                   ram_clr_s;
    logic                   unused_addr_s;

    assign req_ready    = (state_r != WAIT);
    assign accept_s     = req_valid & req_ready;
    assign enter_resp_s = (state_s == RESP) & ~reset;

    // With zero latency the access happens on the accepting edge, so use the live request.
    assign acc_we_s    = LAT_ZERO ? req_we : cap_we_r;
    assign acc_idx_s   = LAT_ZERO ? req_addr[IDX_W+1:2] : cap_idx_r;
    assign acc_wdata_s = LAT_ZERO ? req_wdata : cap_wdata_r;

`ifdef DMEM_RESP_RANGE_CHECK_EN
    logic cap_oor_r;
    logic resp_err_r;
    logic req_oor_s;

    assign req_oor_s     = |req_addr[31:IDX_W+2];
    assign acc_oor_s     = LAT_ZERO ? req_oor_s : cap_oor_r;
    assign resp_err      = resp_err_r;
    assign unused_addr_s = ^req_addr[1:0];

    // Range flag capture and registered error strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_oor_r  <= 1'b0;
            resp_err_r <= 1'b0;
        end else begin
            resp_err_r <= enter_resp_s & acc_oor_s;
            if (accept_s) begin
                cap_oor_r <= req_oor_s;
            end
        end
    end
`else
    assign acc_oor_s     = 1'b0;
    assign resp_err      = 1'b0;
    assign unused_addr_s = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (LAT_ZERO) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == DMEM_CNT_ZERO) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latency counter, response strobe and request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= DMEM_CNT_ZERO;
            resp_valid_r <= 1'b0;
            cap_we_r     <= 1'b0;
            cap_idx_r    <= {IDX_W{1'b0}};
            cap_wdata_r  <= {DMEM_DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            resp_valid_r <= (state_s == RESP);
            if (accept_s) begin
                cnt_r       <= LAT_LOAD;
                cap_we_r    <= req_we;
                cap_idx_r   <= req_addr[IDX_W+1:2];
                cap_wdata_r <= req_wdata;
            end else if ((state_r == WAIT) && (cnt_r != DMEM_CNT_ZERO)) begin
                cnt_r <= cnt_r - DMEM_CNT_ONE;
            end
        end
    end

    // Writes commit and reads sample on the edge entering RESP; reset drops the access.
    assign ram_wr_s  = enter_resp_s & acc_we_s & ~acc_oor_s;
    assign ram_rd_s  = enter_resp_s & ~acc_we_s & ~acc_oor_s;
    assign ram_clr_s = reset | (enter_resp_s & (acc_we_s | acc_oor_s));

    dmem_resp_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_wr_s),
        .rd_en  (ram_rd_s),
        .rd_clr (ram_clr_s),
        .addr   (acc_idx_s),
        .wdata  (acc_wdata_s),
        .rdata  (resp_rdata)
    );

    assign resp_valid = resp_valid_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance, an accept-time
// scoreboard with a memory model, and one task per scenario.
module tb_dmem_responder;

    typedef struct {
        int          dut;
        logic        we;
        logic [5:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

`ifdef DMEM_RESP_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    exp_t        sbq[$];
    logic [31:0] mdl [2][64];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut_l0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: compare responses first, then record the request about to be accepted.
    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (resp_valid[d] === 1'b1) begin
                    checks++;
                    if (sbq.size() == 0 || sbq[0].dut != d) begin
                        errors++;
                        $display("FAIL resp_unexpected dut%0d: resp_valid=1 at cycle %0d, required no response", d, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (resp_rdata[d] !== e.rdata || resp_err[d] !== e.err || cyc != e.due) begin
                            errors++;
                            $display("FAIL resp_data dut%0d: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                                     d, resp_rdata[d], resp_err[d], cyc, e.rdata, e.err, e.due);
                        end
                        if (e.we && !e.err) begin
                            mdl[d][e.idx] = e.wdata;
                        end
                    end
                end
            end
            if (reset === 1'b1) begin
                sbq.delete();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (req_valid[d] === 1'b1 && req_ready[d] === 1'b1) begin
                        e.dut   = d;
                        e.we    = req_we[d];
                        e.idx   = req_addr[d][7:2];
                        e.wdata = req_wdata[d];
                        e.err   = RANGE_EN && (req_addr[d][31:8] != 24'd0);
                        e.rdata = (e.we || e.err) ? 32'd0 : mdl[d][e.idx];
                        e.due   = cyc + 1 + lat_of(d);
                        sbq.push_back(e);
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout dut%0d: req_ready=%b after %0d cycles, required 1", d, req_ready[d], n);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
    endtask

    task automatic test_write_read();
        issue(0, 1'b1, 32'h0000_0000, 32'h1111_1111);
        wait_idle();
        issue(0, 1'b1, 32'h0000_0008, 32'h2222_2222);
        wait_idle();
        issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        checks++;
        if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: ready=%b valid=%b, required 0 0", req_ready[0], resp_valid[0]);
        end
        wait_idle();
        issue(0, 1'b0, 32'h0000_0010, 32'h0);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0020;
        req_wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        req_we[0]    = 1'b0;
        req_wdata[0] = 32'h0;
        while (req_ready[0] !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 2 || resp_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: ready after %0d cycles valid=%b, required 2 cycles valid=1", n, resp_valid[0]);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();
    endtask

    task automatic test_range();
        issue(0, 1'b0, 32'h0000_0100, 32'h0);
        wait_idle();
        issue(0, 1'b1, 32'h0000_0100, 32'h0000_0005);
        wait_idle();
        issue(0, 1'b0, 32'h0000_0000, 32'h0);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic seen;
        issue(0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5);
        reset        = 1'b1;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        @(posedge clk); #1;
        reset        = 1'b0;
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: ready=%b, required 1", req_ready[0]);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_resp: resp_valid seen=1 after reset, required 0");
        end
        reset        = 1'b1;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_wdata[0] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        reset        = 1'b0;
        req_valid[0] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_accept: resp_valid seen=1 for request during reset, required 0");
        end
        issue(0, 1'b0, 32'h0000_0008, 32'h0);
        wait_idle();
    endtask

    task automatic test_low_bits();
        issue(0, 1'b1, 32'h0000_0010, 32'h0000_0077);
        wait_idle();
        issue(0, 1'b0, 32'h0000_0013, 32'h0);
        wait_idle();
    endtask

    task automatic test_idle();
        logic seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_quiet: activity seen=1 with req_valid low, required 0");
        end
    endtask

    task automatic test_lat0();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0;
        addrs[1] = 32'h4;
        addrs[2] = 32'h8;
        issue(1, 1'b1, 32'h0000_0000, 32'h0000_00A0);
        issue(1, 1'b1, 32'h0000_0004, 32'h0000_00A4);
        issue(1, 1'b1, 32'h0000_0008, 32'h0000_00A8);
        wait_idle();
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr[1] = addrs[i];
            @(posedge clk); #1;
            checks++;
            if (resp_valid[1] !== 1'b1) begin
                errors++;
                $display("FAIL lat0_stream: resp_valid=%b on read %0d, required 1", resp_valid[1], i);
            end
        end
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (resp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL lat0_stop: resp_valid=%b after stream, required 0", resp_valid[1]);
        end
        wait_idle();
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_range();
        test_reset_mid();
        test_low_bits();
        test_idle();
        test_lat0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
